iir_in_pacer: RTL

IIR_IN_PACER -- requirements
Module: iir_in_pacer

---
 rtl/iir_pkg.sv | 12 +
 rtl/iir_pacer_fifo.sv | 70 +++++++
 rtl/iir_in_pacer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter front end: sample width and pacer FSM states.
package iir_pkg;

  localparam int SAMPLE_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } pacer_state_t;

endpackage

// File: rtl/iir_pacer_fifo.sv
// Synchronous sample FIFO with a separately tracked level; no fall-through,
// so a sample written into an empty FIFO is readable only on the next cycle.
module iir_pacer_fifo
  import iir_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic signed [SAMPLE_W-1:0] din,
  output logic signed [SAMPLE_W-1:0] dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic signed [SAMPLE_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]           wr_ptr_r;
  logic [PTR_W-1:0]           rd_ptr_r;
  logic [LVL_W-1:0]           level_r;
  logic                       wr_en_s;
  logic                       rd_en_s;

  // full/empty come from the registered level, so a pop never frees a slot for the same-cycle push
  assign full    = (level_r == LVL_W'(DEPTH));
  assign empty   = (level_r == LVL_W'(0));
  assign wr_en_s = push && !full && !clr;
  assign rd_en_s = pop && !empty && !clr;
  assign dout    = mem_r[rd_ptr_r];
  assign level   = level_r;

  // Sample storage write port.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      level_r  <= LVL_W'(0);
    end else if (clr) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      level_r  <= LVL_W'(0);
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/iir_in_pacer.sv
// Input pacer for the IIR filter: buffers upstream samples and emits them at a fixed interval.
// Optional statistics counters are enabled with the IIR_PACER_STATS_EN macro.
module iir_in_pacer
  import iir_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PRIME_LVL = 8,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       flush,
  input  logic [CNT_W-1:0]           interval,
  input  logic signed [SAMPLE_W-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic signed [SAMPLE_W-1:0] data_out,
  output logic                       data_valid_out,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       underrun
`ifdef IIR_PACER_STATS_EN
  ,
  output logic [31:0]                sample_cnt,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  pacer_state_t               state_r;
  pacer_state_t               state_nxt_s;
  logic [CNT_W-1:0]           timer_r;
  logic [CNT_W-1:0]           reload_s;
  logic signed [SAMPLE_W-1:0] data_out_r;
  logic                       data_valid_r;
  logic                       underrun_r;
  logic signed [SAMPLE_W-1:0] fifo_dout_s;
  logic [LVL_W-1:0]           fifo_level_s;
  logic                       fifo_full_s;
  logic                       fifo_empty_s;
  logic                       slot_s;
  logic                       pop_s;
  logic                       skip_s;

  iir_pacer_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (s_valid),
    .pop   (pop_s),
    .din   (s_data),
    .dout  (fifo_dout_s),
    .level (fifo_level_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // An emission slot opens whenever the running timer reaches zero; flush and stop take precedence
  assign slot_s   = (state_r == ST_RUN) && enable && !flush && (timer_r == CNT_W'(0));
  assign pop_s    = slot_s && !fifo_empty_s;
  assign skip_s   = slot_s && fifo_empty_s;
  assign reload_s = (interval == CNT_W'(0)) ? CNT_W'(0) : (interval - CNT_W'(1));

  assign s_ready        = !fifo_full_s;
  assign fifo_level     = fifo_level_s;
  assign data_out       = data_out_r;
  assign data_valid_out = data_valid_r;
  assign underrun       = underrun_r;

  // Pacing FSM next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = enable ? ST_PRIME : ST_IDLE;
    end else if (!enable) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_nxt_s = ST_PRIME;
        ST_PRIME: state_nxt_s = (fifo_level_s >= LVL_W'(PRIME_LVL)) ? ST_RUN : ST_PRIME;
        ST_RUN:   state_nxt_s = ST_RUN;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Interval timer: held at zero outside RUN so the first RUN cycle is an emission slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= CNT_W'(0);
    end else if ((state_r == ST_RUN) && enable && !flush) begin
      if (timer_r == CNT_W'(0)) begin
        timer_r <= reload_s;
      end else begin
        timer_r <= timer_r - CNT_W'(1);
      end
    end else begin
      timer_r <= CNT_W'(0);
    end
  end

  // Emission register, single-cycle valid pulse and sticky underrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_r   <= SAMPLE_W'(0);
      data_valid_r <= 1'b0;
      underrun_r   <= 1'b0;
    end else if (flush) begin
      data_out_r   <= data_out_r;
      data_valid_r <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      data_valid_r <= pop_s;
      if (pop_s) begin
        data_out_r <= fifo_dout_s;
      end
      if (skip_s) begin
        underrun_r <= 1'b1;
      end
    end
  end

`ifdef IIR_PACER_STATS_EN
  logic [31:0] sample_cnt_r;
  logic [15:0] drop_cnt_r;

  assign sample_cnt = sample_cnt_r;
  assign drop_cnt   = drop_cnt_r;

  // Emitted-sample counter wraps; skipped-slot counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_r <= 32'd0;
      drop_cnt_r   <= 16'd0;
    end else if (flush) begin
      sample_cnt_r <= 32'd0;
      drop_cnt_r   <= 16'd0;
    end else begin
      if (pop_s) begin
        sample_cnt_r <= sample_cnt_r + 32'd1;
      end
      if (skip_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end
`endif

endmodule
